// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
// Turns a debounced, synchronous button level into one-cycle event strobes:
// press, release, single short press, long press and double click, plus a
// "held" level while a long press is in progress.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | button released, no sequence in progress
// PRESSED1    | first press down, timing towards a long press
// WAIT_SECOND | first press released, timing the gap for a double click
// PRESSED2    | second press down, double click reported on its release
// LONG_HELD   | hold reached LONG_CYCLES, waiting for release
//
// Parameters:
//   LONG_CYCLES  hold duration (clk cycles) that qualifies a long press
//   GAP_CYCLES   maximum release-to-press gap (clk cycles) for a double click
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   btn_level      debounced synchronous button level, active high
//   press_pulse    one-cycle strobe on each detected press
//   release_pulse  one-cycle strobe on each detected release
//   short_press    one-cycle strobe for a completed single short press
//   long_press     one-cycle strobe when a hold reaches LONG_CYCLES
//   double_click   one-cycle strobe for a completed double click
//   held           high while in LONG_HELD
// -----------------------------------------------------------------------------
module button_event_decoder #(
    parameter int unsigned LONG_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic held
);

    localparam int unsigned MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYCLES - 1);

    generate
        if (LONG_CYCLES < 2 || GAP_CYCLES < 2) begin : g_bad_params
            $error("button_event_decoder: LONG_CYCLES and GAP_CYCLES must both be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PRESSED1    = 3'd1,
        WAIT_SECOND = 3'd2,
        PRESSED2    = 3'd3,
        LONG_HELD   = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             btn_d;
    logic             rise;
    logic             fall;

    assign rise = btn_level & ~btn_d;
    assign fall = ~btn_level & btn_d;

    // Edges are tested before terminal counts so a press/release landing on
    // the same edge as a timeout wins. The counter is cleared on every state
    // change and simply holds outside the two timed states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_d         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            double_click  <= 1'b0;
            held          <= 1'b0;
        end else begin
            btn_d         <= btn_level;
            press_pulse   <= rise;
            release_pulse <= fall;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            double_click  <= 1'b0;

            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= PRESSED1;
                        cnt   <= '0;
                    end
                end

                PRESSED1: begin
                    if (fall) begin
                        state <= WAIT_SECOND;
                        cnt   <= '0;
                    end else if (cnt == LONG_TC) begin
                        state      <= LONG_HELD;
                        cnt        <= '0;
                        long_press <= 1'b1;
                        held       <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_SECOND: begin
                    if (rise) begin
                        state <= PRESSED2;
                        cnt   <= '0;
                    end else if (cnt == GAP_TC) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        short_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                PRESSED2: begin
                    if (fall) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        double_click <= 1'b1;
                    end
                end

                LONG_HELD: begin
                    if (fall) begin
                        state <= IDLE;
                        cnt   <= '0;
                        held  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 The block SHALL have parameter LONG_CYCLES, default 50_000_000; hold duration in clk cycles that qualifies a long press (1 s at 50 MHz).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 12_500_000; maximum release-to-press gap in clk cycles for a double click (250 ms at 50 MHz).
REQ-003 The block SHALL have port clk  input  1  system clock; all registers on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port btn_level  input  1  debounced, synchronous button level, active high.
REQ-006 The block SHALL have port press_pulse  output  1  one-cycle strobe on each detected press.
REQ-007 The block SHALL have port release_pulse  output  1  one-cycle strobe on each detected release.
REQ-008 The block SHALL have port short_press  output  1  one-cycle strobe for a completed single short press.
REQ-009 The block SHALL have port long_press  output  1  one-cycle strobe when a hold reaches LONG_CYCLES.
REQ-010 The block SHALL have port double_click  output  1  one-cycle strobe for a completed double click.
REQ-011 The block SHALL have port held  output  1  level; high while in LONG_HELD.

Function
REQ-012 Edge detection SHALL use a registered copy btn_d: rise = btn_level & ~btn_d, fall = ~btn_level & btn_d.
REQ-013 All outputs SHALL be registered and updated on the same edge as the corresponding state transition; press_pulse/release_pulse SHALL be high exactly the cycle after the edge that samples rise/fall.
REQ-014 FSM states SHALL be IDLE, PRESSED1, WAIT_SECOND, PRESSED2, LONG_HELD.
REQ-015 IDLE: rise -> PRESSED1; otherwise stay.
REQ-016 PRESSED1: fall -> WAIT_SECOND; else cnt == LONG_CYCLES-1 -> LONG_HELD with long_press strobe.
REQ-017 WAIT_SECOND: rise -> PRESSED2; else cnt == GAP_CYCLES-1 -> IDLE with short_press strobe.
REQ-018 PRESSED2: fall -> IDLE with double_click strobe, independent of second-press duration.
REQ-019 LONG_HELD: fall -> IDLE; no short_press or double_click on exit.
REQ-020 A single shared counter cnt SHALL be cleared to 0 on every state-changing edge and increment by 1 on each other edge in PRESSED1/WAIT_SECOND; width = $clog2(max(LONG_CYCLES, GAP_CYCLES)); cnt SHALL hold (not wrap) in other states.
REQ-021 Resulting latency: long_press rises exactly LONG_CYCLES cycles after press_pulse rises; short_press rises exactly GAP_CYCLES cycles after release_pulse rises.
REQ-022 Simultaneous events: an edge (rise/fall) SHALL take priority over a terminal count in the same cycle.
REQ-023 At most one of short_press, long_press, double_click SHALL be high in any cycle.
REQ-024 LONG_CYCLES < 2 or GAP_CYCLES < 2 SHALL be rejected at elaboration.

Reset
REQ-025 While rst is high: state = IDLE, cnt = 0, btn_d = 0, all outputs 0, independent of clk.
REQ-026 A button already high at rst deassertion SHALL be treated as a fresh press (press_pulse on first edge); a reset mid-sequence SHALL discard the sequence with no event strobe.

Verification (LONG_CYCLES=8, GAP_CYCLES=4)
REQ-027 Assert rst with btn_level=1 mid-PRESSED1 -> all outputs 0 immediately; deassert -> press_pulse high 1 cycle after the first edge.
REQ-028 Press 3 cycles, release -> press_pulse, release_pulse, short_press 4 cycles after release_pulse; no other strobe.
REQ-029 Press 20 cycles -> long_press 8 cycles after press_pulse, held high until the cycle release_pulse rises, then 0; no short_press.
REQ-030 Press 2, release 2, press 2, release -> double_click coincident with second release_pulse; no short_press.
REQ-031 Second rise sampled at the edge where cnt == 3 in WAIT_SECOND -> PRESSED2, no short_press.
REQ-032 Fall sampled at the edge where cnt == 7 in PRESSED1 -> WAIT_SECOND, no long_press, held stays 0.
